// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int   WORD_BYTES = 4;
    localparam logic ERR_NONE   = 1'b0;
    localparam logic ERR_ACCESS = 1'b1;

    // Misaligned, or above the word array (any byte-address bit at or beyond addr_w+2 set).
    function automatic logic access_err(input logic [31:0] addr, input int addr_w);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous byte-enabled write, combinational read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WORD_BYTES-1:0] be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data responder: one request at a time, fixed access latency, stall to hazard logic.
// Handshake: a request is taken on any cycle where req_valid && req_ready; rsp_valid pulses for one cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output state_t      state
);

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    state_t      state_next;
    logic [3:0]  count;
    logic [3:0]  count_next;
    logic        accept;
    logic        completing;

    logic        hold_we;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic [3:0]  hold_be;

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_be;
    logic        cur_err;
    logic [31:0] mem_rdata;

    assign req_ready  = (state == IDLE) || (state == RESP);
    assign accept     = req_valid && req_ready;
    assign stall      = req_valid && !req_ready;
    assign completing = (state_next == RESP);

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 1) ? RESP : BUSY;
                    count_next = LAT_LOAD;
                end
            end
            BUSY: begin
                count_next = count - 4'd1;
                if (count == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (accept) begin
                    state_next = (LATENCY == 1) ? RESP : BUSY;
                    count_next = LAT_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    // With single-cycle latency the completing request is the one being accepted right now,
    // so it must come straight from the inputs rather than the holding registers.
    always_comb begin
        if (LATENCY == 1) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end else begin
            cur_we    = hold_we;
            cur_addr  = hold_addr;
            cur_wdata = hold_wdata;
            cur_be    = hold_be;
        end
    end

    assign cur_err = access_err(cur_addr, ADDR_W);

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (completing && cur_we && !cur_err && !reset),
        .be    (cur_be),
        .addr  (cur_addr[ADDR_W+1:2]),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_we    <= req_we;
            hold_addr  <= req_addr;
            hold_wdata <= req_wdata;
            hold_be    <= req_be;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= ERR_NONE;
        end else begin
            state     <= state_next;
            count     <= count_next;
            rsp_valid <= completing;
            if (completing) begin
                rsp_err   <= cur_err ? ERR_ACCESS : ERR_NONE;
                rsp_rdata <= (cur_we || cur_err) ? 32'd0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder at latencies 1, 2 and 4: directed table, timing sequences, random traffic.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int NI = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_we    [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic [3:0]  req_be    [NI];
    logic        rsp_valid [NI];
    logic [31:0] rsp_rdata [NI];
    logic        rsp_err   [NI];
    logic        stall     [NI];
    state_t      st        [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .ADDR_W  (8),
            .LATENCY ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .stall     (stall[g]),
            .state     (st[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // ---------------- reference model ----------------
    // One outstanding request per responder; it completes exactly LATENCY cycles after acceptance.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          due;
    } txn_t;

    txn_t        pend    [NI];
    bit          pend_v  [NI];
    logic [31:0] mem_m   [NI][256];
    logic [31:0] last_rd [NI];
    logic        last_err[NI];
    bit          armed = 1'b0;

    function automatic bit bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h400);
    endfunction

    task automatic mon_step(input int k);
        bit          exp_ready;
        bit          exp_rv;
        logic [31:0] word;
        string       tag;
        tag       = $sformatf("mon%0d@%0d", k, cyc);
        exp_ready = !(pend_v[k] && pend[k].due > cyc);
        exp_rv    = pend_v[k] && (pend[k].due == cyc);
        chk({tag, " req_ready"}, 32'(req_ready[k]), 32'(exp_ready));
        chk({tag, " stall"}, 32'(stall[k]), 32'(req_valid[k] && !exp_ready));
        chk({tag, " rsp_valid"}, 32'(rsp_valid[k]), 32'(exp_rv));
        if (exp_rv) begin
            last_err[k] = bad_addr(pend[k].addr);
            last_rd[k]  = 32'd0;
            if (!last_err[k]) begin
                word = mem_m[k][pend[k].addr[9:2]];
                if (pend[k].we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (pend[k].be[b]) word[8*b +: 8] = pend[k].wdata[8*b +: 8];
                    end
                    mem_m[k][pend[k].addr[9:2]] = word;
                end else begin
                    last_rd[k] = word;
                end
            end
            pend_v[k] = 1'b0;
        end
        chk({tag, " rsp_rdata"}, rsp_rdata[k], last_rd[k]);
        chk({tag, " rsp_err"}, 32'(rsp_err[k]), 32'(last_err[k]));
        if (!reset && req_valid[k] && exp_ready) begin
            pend[k].we    = req_we[k];
            pend[k].addr  = req_addr[k];
            pend[k].wdata = req_wdata[k];
            pend[k].be    = req_be[k];
            pend[k].due   = cyc + lat_of(k);
            pend_v[k]     = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (armed) mon_step(k);
                if (reset) begin
                    pend_v[k]   = 1'b0;
                    last_rd[k]  = 32'd0;
                    last_err[k] = 1'b0;
                end
            end
            if (reset) armed = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        req_valid[k] = 1'b0;
    endtask

    // Holds the request until accepted; returns one step after the accepting edge with valid still high.
    task automatic issue(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        bit acc;
        acc          = 1'b0;
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_be[k]    = be;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready[k];
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            timeout($sformatf("issue%0d", k));
            req_valid[k] = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int k, output logic [31:0] rd, output logic er, output bit got);
        got = 1'b0;
        rd  = 32'd0;
        er  = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid[k]) begin
                got = 1'b1;
                rd  = rsp_rdata[k];
                er  = rsp_err[k];
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [17];
    logic [32:0] exp_q[$];

    initial begin
        logic [31:0] rd;
        logic        er;
        bit          got;
        logic [32:0] e;
        logic [31:0] a;
        int          r;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0013, 32'h0,         4'hF, 32'h0, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0000, 32'h0102_0304, 4'hF, 32'h0, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0102_0304, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_03FC, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0402, 32'h0,         4'hF, 32'h0, 1'b1};
        vecs[14] = '{1'b1, 32'h0000_0022, 32'h9999_9999, 4'hF, 32'h0, 1'b1};
        vecs[15] = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'h11BB_33DD, 1'b0};
        vecs[16] = '{1'b0, 32'h8000_0000, 32'h0,         4'hF, 32'h0, 1'b1};

        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = 32'd0;
            req_wdata[k] = 32'd0;
            req_be[k]    = 4'd0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Quiet after reset.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("rst%0d ready", k), 32'(req_ready[k]), 32'd1);
                chk($sformatf("rst%0d rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
                chk($sformatf("rst%0d stall", k), 32'(stall[k]), 32'd0);
                chk($sformatf("rst%0d rdata", k), rsp_rdata[k], 32'd0);
                chk($sformatf("rst%0d err", k), 32'(rsp_err[k]), 32'd0);
                chk($sformatf("rst%0d state", k), 32'(st[k]), 32'(IDLE));
            end
            @(posedge clk);
            #1;
        end

        // Give every word a known value so the model can predict all later loads.
        for (int k = 0; k < NI; k++) begin
            for (int w = 0; w < 256; w++) begin
                issue(k, 1'b1, 32'(w) << 2, $urandom, 4'hF);
            end
            idle(k);
            idle_cycles(6);
        end

        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 17; i++) begin
                exp_q.push_back({vecs[i].exp_err, vecs[i].exp_rdata});
                issue(k, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
                idle(k);
                wait_rsp(k, rd, er, got);
                e = exp_q.pop_front();
                if (got) begin
                    chk($sformatf("vec%0d.%0d rdata", k, i), rd, e[31:0]);
                    chk($sformatf("vec%0d.%0d err", k, i), 32'(er), 32'(e[32]));
                end else begin
                    timeout($sformatf("vec%0d.%0d rsp", k, i));
                end
            end
        end

        // Latency 2: store then load, exact cycle positions.
        idle_cycles(3);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h10;
        req_wdata[1] = 32'hDEAD_BEEF; req_be[1] = 4'hF;
        @(negedge clk);
        chk("lat2 T ready", 32'(req_ready[1]), 32'd1);
        chk("lat2 T rsp_valid", 32'(rsp_valid[1]), 32'd0);
        @(posedge clk); #1;
        req_we[1] = 1'b0;
        @(negedge clk);
        chk("lat2 T+1 stall", 32'(stall[1]), 32'd1);
        chk("lat2 T+1 rsp_valid", 32'(rsp_valid[1]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat2 T+2 rsp_valid", 32'(rsp_valid[1]), 32'd1);
        chk("lat2 T+2 rdata", rsp_rdata[1], 32'd0);
        chk("lat2 T+2 ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("lat2 T+3 rsp_valid", 32'(rsp_valid[1]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat2 T+4 rsp_valid", 32'(rsp_valid[1]), 32'd1);
        chk("lat2 T+4 rdata", rsp_rdata[1], 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Latency 1: three back-to-back loads give three consecutive responses.
        issue(0, 1'b1, 32'h0, 32'hA0A0_A0A0, 4'hF);
        issue(0, 1'b1, 32'h4, 32'hB1B1_B1B1, 4'hF);
        issue(0, 1'b1, 32'h8, 32'hC2C2_C2C2, 4'hF);
        idle(0);
        idle_cycles(2);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h0;
        @(negedge clk);
        chk("lat1 c0 stall", 32'(stall[0]), 32'd0);
        chk("lat1 c0 rsp_valid", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk); #1;
        req_addr[0] = 32'h4;
        @(negedge clk);
        chk("lat1 c1 stall", 32'(stall[0]), 32'd0);
        chk("lat1 c1 rsp_valid", 32'(rsp_valid[0]), 32'd1);
        chk("lat1 c1 rdata", rsp_rdata[0], 32'hA0A0_A0A0);
        @(posedge clk); #1;
        req_addr[0] = 32'h8;
        @(negedge clk);
        chk("lat1 c2 stall", 32'(stall[0]), 32'd0);
        chk("lat1 c2 rsp_valid", 32'(rsp_valid[0]), 32'd1);
        chk("lat1 c2 rdata", rsp_rdata[0], 32'hB1B1_B1B1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("lat1 c3 rsp_valid", 32'(rsp_valid[0]), 32'd1);
        chk("lat1 c3 rdata", rsp_rdata[0], 32'hC2C2_C2C2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat1 c4 rsp_valid", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk); #1;

        // Reset while busy drops the pending store.
        issue(1, 1'b1, 32'h30, 32'h5555_AAAA, 4'hF);
        idle(1);
        wait_rsp(1, rd, er, got);
        if (!got) timeout("rstbusy setup rsp");
        idle_cycles(2);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h30;
        req_wdata[1] = 32'h1234_5678; req_be[1] = 4'hF;
        @(negedge clk);
        chk("rstbusy accept ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rstbusy busy rsp_valid", 32'(rsp_valid[1]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstbusy after rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("rstbusy after ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstbusy late rsp_valid", 32'(rsp_valid[1]), 32'd0);
        @(posedge clk); #1;
        issue(1, 1'b0, 32'h30, 32'h0, 4'hF);
        idle(1);
        wait_rsp(1, rd, er, got);
        if (got) chk("rstbusy reload rdata", rd, 32'h5555_AAAA);
        else timeout("rstbusy reload rsp");

        // Random traffic, checked cycle by cycle by the model.
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 150; n++) begin
                if ($urandom_range(0, 3) == 0) begin
                    idle(k);
                    idle_cycles($urandom_range(1, 3));
                end
                if ($urandom_range(0, 29) == 0) begin
                    idle(k);
                    pulse_reset();
                end
                r = $urandom_range(0, 9);
                if (r < 8)       a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                else if (r == 8) a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
                else             a = $urandom | 32'h400;
                issue(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            end
            idle(k);
            idle_cycles(8);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
